// File: rtl/mrv1_mt_issue_sched.sv
// mrv1_mt_issue_sched: per-thread decode buffers with scoreboarded round-robin issue; define MRV1_ISSUE_WB_BYPASS_EN to let a same-cycle writeback unblock its dependent.
module mrv1_mt_issue_sched #(
  parameter int NUM_THREADS_P   = 8,
  parameter int DEC_BUF_SZ_P    = 4,
  parameter int PAYLOAD_WIDTH_P = 64,
  parameter int NUM_FU_P        = 4,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  parameter int CNT_WIDTH_LP    = $clog2(DEC_BUF_SZ_P) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  dec_vld_i,
  output logic [NUM_THREADS_P-1:0]              dec_rdy_o,
  input  logic [TID_WIDTH_LP-1:0]               dec_tid_i,
  input  logic [PAYLOAD_WIDTH_P-1:0]            dec_payload_i,
  input  logic [NUM_FU_P-1:0]                   dec_fu_req_i,
  input  logic                                  dec_rs0_vld_i,
  input  logic                                  dec_rs1_vld_i,
  input  logic [RF_ADDR_WIDTH_P-1:0]            dec_rs0_addr_i,
  input  logic [RF_ADDR_WIDTH_P-1:0]            dec_rs1_addr_i,
  input  logic                                  dec_rd_vld_i,
  input  logic [RF_ADDR_WIDTH_P-1:0]            dec_rd_addr_i,
  input  logic                                  flush_vld_i,
  input  logic [TID_WIDTH_LP-1:0]               flush_tid_i,
  input  logic                                  wb_vld_i,
  input  logic [TID_WIDTH_LP-1:0]               wb_tid_i,
  input  logic [RF_ADDR_WIDTH_P-1:0]            wb_rd_addr_i,
  input  logic [NUM_FU_P-1:0]                   exec_fu_rdy_i,
  output logic                                  issue_vld_o,
  output logic [TID_WIDTH_LP-1:0]               issue_tid_o,
  output logic [NUM_FU_P-1:0]                   issue_fu_req_o,
  output logic [PAYLOAD_WIDTH_P-1:0]            issue_payload_o,
  output logic [RF_ADDR_WIDTH_P-1:0]            issue_rs0_addr_o,
  output logic [RF_ADDR_WIDTH_P-1:0]            issue_rs1_addr_o,
  output logic                                  issue_rd_vld_o,
  output logic [RF_ADDR_WIDTH_P-1:0]            issue_rd_addr_o,
  output logic [NUM_THREADS_P*CNT_WIDTH_LP-1:0] buf_cnt_o
);
  localparam int PTR_W = $clog2(DEC_BUF_SZ_P);
  localparam int RF_N  = 1 << RF_ADDR_WIDTH_P;
  typedef struct packed {
    logic [PAYLOAD_WIDTH_P-1:0] pay;
    logic [NUM_FU_P-1:0]        fu;
    logic                       rs0_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rs0;
    logic                       rs1_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rs1;
    logic                       rd_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rd;
  } ent_t;
  ent_t                      buf_q [NUM_THREADS_P][DEC_BUF_SZ_P];
  ent_t                      head [NUM_THREADS_P];
  ent_t                      dec_ent;
  logic [PTR_W-1:0]          wr_q [NUM_THREADS_P];
  logic [PTR_W-1:0]          rd_q [NUM_THREADS_P];
  logic [CNT_WIDTH_LP-1:0]   cnt_q [NUM_THREADS_P];
  logic [RF_N-1:0]           sb_q [NUM_THREADS_P];
  logic [RF_N-1:0]           sb_d [NUM_THREADS_P];
  logic [RF_N-1:0]           busy [NUM_THREADS_P];
  logic [RF_N-1:0]           wb_clr [NUM_THREADS_P];
  logic [NUM_THREADS_P-1:0]  cand, enq, deq, flush;
  logic [TID_WIDTH_LP-1:0]   rr_q, gnt_tid, idx;
  logic                      gnt;
  assign dec_ent = '{pay: dec_payload_i, fu: dec_fu_req_i, rs0_vld: dec_rs0_vld_i, rs0: dec_rs0_addr_i,
                     rs1_vld: dec_rs1_vld_i, rs1: dec_rs1_addr_i, rd_vld: dec_rd_vld_i, rd: dec_rd_addr_i};
  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      head[t]      = buf_q[t][rd_q[t]];
      flush[t]     = flush_vld_i && flush_tid_i == TID_WIDTH_LP'(t);
      wb_clr[t]    = (wb_vld_i && wb_tid_i == TID_WIDTH_LP'(t)) ? (RF_N'(1) << wb_rd_addr_i) : '0;
`ifdef MRV1_ISSUE_WB_BYPASS_EN
      busy[t]      = sb_q[t] & ~wb_clr[t];
`else
      busy[t]      = sb_q[t];
`endif
      dec_rdy_o[t] = cnt_q[t] != CNT_WIDTH_LP'(DEC_BUF_SZ_P);
      buf_cnt_o[t*CNT_WIDTH_LP +: CNT_WIDTH_LP] = cnt_q[t];
      cand[t]      = cnt_q[t] != '0 && !flush[t] && |(head[t].fu & exec_fu_rdy_i) &&
                     !(head[t].rs0_vld && head[t].rs0 != '0 && busy[t][head[t].rs0]) &&
                     !(head[t].rs1_vld && head[t].rs1 != '0 && busy[t][head[t].rs1]) &&
                     !(head[t].rd_vld && head[t].rd != '0 && busy[t][head[t].rd]);
    end
  end
  // Offset NUM_THREADS_P wraps back to rr_q itself, giving the last granted thread lowest priority.
  always_comb begin
    gnt     = 1'b0;
    gnt_tid = rr_q;
    idx     = rr_q;
    for (int i = 1; i <= NUM_THREADS_P; i++) begin
      idx = rr_q + TID_WIDTH_LP'(i);
      if (!gnt && cand[idx]) begin
        gnt     = 1'b1;
        gnt_tid = idx;
      end
    end
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      deq[t]     = gnt && gnt_tid == TID_WIDTH_LP'(t);
      enq[t]     = dec_vld_i && dec_tid_i == TID_WIDTH_LP'(t) && dec_rdy_o[t] && !flush[t];
      sb_d[t]    = (sb_q[t] & ~wb_clr[t]) | ((deq[t] && head[t].rd_vld) ? (RF_N'(1) << head[t].rd) : '0);
      sb_d[t][0] = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        wr_q[t]  <= '0;
        rd_q[t]  <= '0;
        cnt_q[t] <= '0;
        sb_q[t]  <= '0;
      end
      rr_q             <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
      issue_vld_o      <= 1'b0;
      issue_tid_o      <= '0;
      issue_fu_req_o   <= '0;
      issue_payload_o  <= '0;
      issue_rs0_addr_o <= '0;
      issue_rs1_addr_o <= '0;
      issue_rd_vld_o   <= 1'b0;
      issue_rd_addr_o  <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        if (flush[t]) begin
          wr_q[t]  <= '0;
          rd_q[t]  <= '0;
          cnt_q[t] <= '0;
        end else begin
          if (enq[t]) begin
            buf_q[t][wr_q[t]] <= dec_ent;
            wr_q[t]           <= wr_q[t] + 1'b1;
          end
          if (deq[t]) rd_q[t] <= rd_q[t] + 1'b1;
          cnt_q[t] <= cnt_q[t] + CNT_WIDTH_LP'(enq[t]) - CNT_WIDTH_LP'(deq[t]);
        end
        sb_q[t] <= sb_d[t];
      end
      if (gnt) rr_q <= gnt_tid;
      issue_vld_o      <= gnt;
      issue_tid_o      <= gnt ? gnt_tid : '0;
      issue_fu_req_o   <= gnt ? head[gnt_tid].fu : '0;
      issue_payload_o  <= gnt ? head[gnt_tid].pay : '0;
      issue_rs0_addr_o <= gnt ? head[gnt_tid].rs0 : '0;
      issue_rs1_addr_o <= gnt ? head[gnt_tid].rs1 : '0;
      issue_rd_vld_o   <= gnt && head[gnt_tid].rd_vld;
      issue_rd_addr_o  <= gnt ? head[gnt_tid].rd : '0;
    end
  end
endmodule
